// File: rtl/tlc_pkg.sv
// Shared types and light encodings for the multi-phase traffic controller.
package tlc_pkg;

  typedef enum logic [1:0] {
    ST_GREEN   = 2'd0,
    ST_YELLOW  = 2'd1,
    ST_ALL_RED = 2'd2,
    ST_WALK    = 2'd3
  } tlc_state_e;

  // {red, yellow, green}
  localparam logic [2:0] LIGHT_RED    = 3'b100;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_GREEN  = 3'b001;
  localparam logic [2:0] LIGHT_OFF    = 3'b000;

endpackage

// File: rtl/tlc_phase_arbiter.sv
// Rotating-priority phase selector: first demanded phase cyclically after
// the current one, wrapping back to the current phase if nothing else asks.
module tlc_phase_arbiter #(
  parameter int unsigned NUM_PHASES = 3
) (
  input  logic [NUM_PHASES-1:0]         demand,
  input  logic [$clog2(NUM_PHASES)-1:0] current,
  output logic [$clog2(NUM_PHASES)-1:0] next_phase
);

  localparam int unsigned PW = $clog2(NUM_PHASES);

  logic found_hi;
  logic found_lo;
  logic [PW-1:0] hi_phase;
  logic [PW-1:0] lo_phase;

  // Two ascending passes: phases above current first, then the wrap-around
  // range up to and including current.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    hi_phase = '0;
    lo_phase = '0;
    for (int unsigned i = 0; i < NUM_PHASES; i++) begin
      if (demand[i] && (i > 32'(current)) && !found_hi) begin
        hi_phase = PW'(i);
        found_hi = 1'b1;
      end
      if (demand[i] && (i <= 32'(current)) && !found_lo) begin
        lo_phase = PW'(i);
        found_lo = 1'b1;
      end
    end
    next_phase = found_hi ? hi_phase : lo_phase;
  end

endmodule

// File: rtl/multi_phase_traffic_controller.sv
// Actuated N-phase traffic controller with all-red clearance and exclusive
// pedestrian WALK. Optional flashing mode under `TLC_FLASH_MODE_EN.
module multi_phase_traffic_controller
  import tlc_pkg::*;
#(
  parameter int unsigned NUM_PHASES  = 3,
  parameter int unsigned TIMER_W     = 8,
  parameter int unsigned GREEN_MIN   = 4,
  parameter int unsigned GREEN_MAX   = 12,
  parameter int unsigned YELLOW_TIME = 3,
  parameter int unsigned ALLRED_TIME = 1,
`ifdef TLC_FLASH_MODE_EN
  parameter int unsigned FLASH_HALF  = 4,
`endif
  parameter int unsigned WALK_TIME   = 5
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_PHASES-1:0]         veh_sensor,
  input  logic                          ped_button,
`ifdef TLC_FLASH_MODE_EN
  input  logic                          flash_mode,
`endif
  output logic [3*NUM_PHASES-1:0]       lights,
  output logic                          ped_walk,
  output logic [$clog2(NUM_PHASES)-1:0] active_phase,
  output logic                          ped_pending
);

  localparam int unsigned PW = $clog2(NUM_PHASES);

  localparam logic [TIMER_W-1:0] G_MIN_M1 = TIMER_W'(GREEN_MIN - 1);
  localparam logic [TIMER_W-1:0] G_MAX_M1 = TIMER_W'(GREEN_MAX - 1);
  localparam logic [TIMER_W-1:0] Y_M1     = TIMER_W'(YELLOW_TIME - 1);
  localparam logic [TIMER_W-1:0] AR_M1    = TIMER_W'(ALLRED_TIME - 1);
  localparam logic [TIMER_W-1:0] W_M1     = TIMER_W'(WALK_TIME - 1);

  localparam logic [3*NUM_PHASES-1:0] LIGHTS_RST = {{(NUM_PHASES-1){LIGHT_RED}}, LIGHT_GREEN};

  tlc_state_e               state_q, state_d;
  logic [TIMER_W-1:0]       timer_q, timer_d;
  logic [PW-1:0]            phase_q, phase_d;
  logic [NUM_PHASES-1:0]    veh_demand_q, veh_demand_d;
  logic                     ped_pending_q, ped_pending_d;
  logic [3*NUM_PHASES-1:0]  lights_q, lights_d;
  logic                     ped_walk_q, ped_walk_d;

  logic [NUM_PHASES-1:0]    cur_mask;
  logic [NUM_PHASES-1:0]    green_mask;
  logic [NUM_PHASES-1:0]    arb_demand;
  logic [PW-1:0]            arb_next;
  logic                     conflict;
  logic                     enter_green;
  logic                     enter_walk;

`ifdef TLC_FLASH_MODE_EN
  localparam int unsigned FW = (FLASH_HALF > 1) ? $clog2(2 * FLASH_HALF) : 1;
  localparam logic [FW-1:0] FLASH_LAST = FW'(2 * FLASH_HALF - 1);
  localparam logic [FW-1:0] FLASH_LIT  = FW'(FLASH_HALF);

  logic          flash_q, flash_d;
  logic [FW-1:0] flash_cnt_q, flash_cnt_d;
`endif

  assign arb_demand = veh_demand_q | NUM_PHASES'(1);

  tlc_phase_arbiter #(
    .NUM_PHASES(NUM_PHASES)
  ) u_arbiter (
    .demand    (arb_demand),
    .current   (phase_q),
    .next_phase(arb_next)
  );

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    phase_d     = phase_q;
    enter_green = 1'b0;
    enter_walk  = 1'b0;

    cur_mask   = NUM_PHASES'(1) << phase_q;
    green_mask = (state_q == ST_GREEN) ? cur_mask : '0;
    conflict   = ped_pending_q || (phase_q != '0) || (|(veh_demand_q & ~cur_mask));

    unique case (state_q)
      ST_GREEN: begin
        if (conflict && (timer_q >= G_MIN_M1) &&
            (!veh_sensor[phase_q] || (timer_q == G_MAX_M1))) begin
          state_d = ST_YELLOW;
          timer_d = '0;
        end else if (timer_q != G_MAX_M1) begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_YELLOW: begin
        if (timer_q == Y_M1) begin
          state_d = ST_ALL_RED;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_ALL_RED: begin
        if (timer_q == AR_M1) begin
          timer_d = '0;
          if (ped_pending_q) begin
            state_d    = ST_WALK;
            enter_walk = 1'b1;
          end else begin
            enter_green = 1'b1;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_WALK: begin
        if (timer_q == W_M1) begin
          timer_d     = '0;
          enter_green = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_GREEN;
        timer_d = '0;
      end
    endcase

    if (enter_green) begin
      state_d = ST_GREEN;
      phase_d = arb_next;
    end

`ifdef TLC_FLASH_MODE_EN
    // Flashing freezes the sequencer in ALL_RED; release restarts the interval.
    flash_d     = flash_mode;
    flash_cnt_d = '0;
    if (flash_mode) begin
      state_d     = ST_ALL_RED;
      timer_d     = (state_q == ST_ALL_RED) ? timer_q : '0;
      phase_d     = phase_q;
      enter_green = 1'b0;
      enter_walk  = 1'b0;
      if (flash_q) begin
        flash_cnt_d = (flash_cnt_q == FLASH_LAST) ? '0 : flash_cnt_q + 1'b1;
      end
    end else if (flash_q) begin
      state_d     = ST_ALL_RED;
      timer_d     = '0;
      phase_d     = phase_q;
      enter_green = 1'b0;
      enter_walk  = 1'b0;
    end
`endif

    // Entering green serves the phase, so its clear beats a same-cycle set.
    veh_demand_d = veh_demand_q | (veh_sensor & ~green_mask);
    if (enter_green) begin
      veh_demand_d = veh_demand_d & ~(NUM_PHASES'(1) << phase_d);
    end
    ped_pending_d = ped_button || (ped_pending_q && !enter_walk);

    lights_d = '0;
    for (int unsigned i = 0; i < NUM_PHASES; i++) begin
      if ((state_d == ST_GREEN) && (phase_d == PW'(i))) begin
        lights_d[3*i +: 3] = LIGHT_GREEN;
      end else if ((state_d == ST_YELLOW) && (phase_d == PW'(i))) begin
        lights_d[3*i +: 3] = LIGHT_YELLOW;
      end else begin
        lights_d[3*i +: 3] = LIGHT_RED;
      end
    end
    ped_walk_d = (state_d == ST_WALK);

`ifdef TLC_FLASH_MODE_EN
    if (flash_mode) begin
      for (int unsigned i = 0; i < NUM_PHASES; i++) begin
        if (flash_cnt_d < FLASH_LIT) begin
          lights_d[3*i +: 3] = (i == 0) ? LIGHT_YELLOW : LIGHT_RED;
        end else begin
          lights_d[3*i +: 3] = LIGHT_OFF;
        end
      end
      ped_walk_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_GREEN;
      timer_q       <= '0;
      phase_q       <= '0;
      veh_demand_q  <= '0;
      ped_pending_q <= 1'b0;
      lights_q      <= LIGHTS_RST;
      ped_walk_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      phase_q       <= phase_d;
      veh_demand_q  <= veh_demand_d;
      ped_pending_q <= ped_pending_d;
      lights_q      <= lights_d;
      ped_walk_q    <= ped_walk_d;
    end
  end

`ifdef TLC_FLASH_MODE_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flash_q     <= 1'b0;
      flash_cnt_q <= '0;
    end else begin
      flash_q     <= flash_d;
      flash_cnt_q <= flash_cnt_d;
    end
  end
`endif

  assign lights       = lights_q;
  assign ped_walk     = ped_walk_q;
  assign active_phase = phase_q;
  assign ped_pending  = ped_pending_q;

endmodule

// File: tb/tb_multi_phase_traffic_controller.sv
// Self-checking bench for multi_phase_traffic_controller (3 phases, default timing).
module tb_multi_phase_traffic_controller;

  localparam int N    = 3;
  localparam int GMIN = 4;
  localparam int GMAX = 12;
  localparam int YT   = 3;
  localparam int ART  = 1;
  localparam int WT   = 5;

  localparam logic [8:0] RST_LIGHTS = 9'b100_100_001;
  localparam logic [8:0] ALL_RED    = 9'b100_100_100;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] veh_sensor;
  logic         ped_button;
  logic [8:0]   lights;
  logic         ped_walk;
  logic [1:0]   active_phase;
  logic         ped_pending;
`ifdef TLC_FLASH_MODE_EN
  logic         flash_mode;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  multi_phase_traffic_controller #(
    .NUM_PHASES (N),
    .TIMER_W    (8),
    .GREEN_MIN  (GMIN),
    .GREEN_MAX  (GMAX),
    .YELLOW_TIME(YT),
    .ALLRED_TIME(ART),
`ifdef TLC_FLASH_MODE_EN
    .FLASH_HALF (4),
`endif
    .WALK_TIME  (WT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .veh_sensor  (veh_sensor),
    .ped_button  (ped_button),
`ifdef TLC_FLASH_MODE_EN
    .flash_mode  (flash_mode),
`endif
    .lights      (lights),
    .ped_walk    (ped_walk),
    .active_phase(active_phase),
    .ped_pending (ped_pending)
  );

  // ---------------- reference model (interval-level view) ----------------
  int       m_kind;   // 0 green, 1 yellow, 2 all-red, 3 walk
  int       m_age;    // cycles already spent in the current interval
  int       m_phase;
  bit [N-1:0] m_dem;
  bit       m_ped;

  function automatic int model_next_phase();
    for (int k = 1; k <= N; k++) begin
      int p;
      p = (m_phase + k) % N;
      if (p == 0 || m_dem[p]) return p;
    end
    return 0;
  endfunction

  function automatic logic [8:0] model_lights();
    logic [8:0] l;
    for (int i = 0; i < N; i++) begin
      if (m_kind == 0 && m_phase == i)      l[3*i +: 3] = 3'b001;
      else if (m_kind == 1 && m_phase == i) l[3*i +: 3] = 3'b010;
      else                                  l[3*i +: 3] = 3'b100;
    end
    return l;
  endfunction

  task automatic model_reset();
    m_kind = 0; m_age = 0; m_phase = 0; m_dem = '0; m_ped = 1'b0;
  endtask

  task automatic model_step(input bit [N-1:0] s, input bit b);
    bit [N-1:0] sets;
    int  nk, na, np;
    bit  to_green, to_walk, conflict;
    to_green = 0; to_walk = 0;
    nk = m_kind; na = m_age + 1; np = m_phase;
    for (int i = 0; i < N; i++)
      sets[i] = s[i] && !(m_kind == 0 && m_phase == i);
    case (m_kind)
      0: begin
        conflict = (m_phase != 0) || m_ped;
        for (int j = 0; j < N; j++) if (j != m_phase && m_dem[j]) conflict = 1;
        if (conflict && m_age >= GMIN - 1 && (!s[m_phase] || m_age == GMAX - 1)) begin
          nk = 1; na = 0;
        end else if (na > GMAX - 1) na = GMAX - 1;
      end
      1: if (m_age == YT - 1) begin nk = 2; na = 0; end
      2: if (m_age == ART - 1) begin
           na = 0;
           if (m_ped) begin nk = 3; to_walk = 1; end
           else to_green = 1;
         end
      default: if (m_age == WT - 1) begin na = 0; to_green = 1; end
    endcase
    if (to_green) begin nk = 0; np = model_next_phase(); end
    m_dem = m_dem | sets;
    if (to_green) m_dem[np] = 1'b0;
    m_ped = b || (m_ped && !to_walk);
    m_kind = nk; m_age = na; m_phase = np;
  endtask

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, " lights"}, 32'(lights), 32'(model_lights()));
    check({tag, " ped_walk"}, 32'(ped_walk), 32'(m_kind == 3));
    check({tag, " active_phase"}, 32'(active_phase), 32'(m_phase));
    check({tag, " ped_pending"}, 32'(ped_pending), 32'(m_ped));
  endtask

  // Called #1 after an edge; drives, clocks, advances the model, compares.
  task automatic step(input logic [N-1:0] s, input logic b, input string tag);
    veh_sensor = s;
    ped_button = b;
    @(posedge clk);
    model_step(s, b);
    #1;
    check_model(tag);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    veh_sensor = '0;
    ped_button = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    check("reset lights", 32'(lights), 32'(RST_LIGHTS));
    check("reset ped_walk", 32'(ped_walk), 32'd0);
    check("reset active_phase", 32'(active_phase), 32'd0);
    check("reset ped_pending", 32'(ped_pending), 32'd0);
  endtask

  typedef struct {
    logic [N-1:0] sens;
    logic [8:0]   lights;
    logic [1:0]   phase;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [N-1:0] s, input logic [8:0] l, input logic [1:0] p);
    vec_t v;
    v.sens = s; v.lights = l; v.phase = p;
    tbl.push_back(v);
  endtask

  initial begin
    int green_cnt, walk_cnt, first_green_after_walk;
    bit saw_p1_green, done, prev_walk;
    veh_sensor = '0;
    ped_button = 1'b0;
    reset      = 1'b1;
`ifdef TLC_FLASH_MODE_EN
    flash_mode = 1'b0;
`endif

    // Phase-1 single-cycle request, hand-derived timeline.
    add(3'b010, 9'b100_100_001, 2'd0);
    add(3'b000, 9'b100_100_001, 2'd0);
    add(3'b000, 9'b100_100_001, 2'd0);
    for (int i = 0; i < 3; i++) add(3'b000, 9'b100_100_010, 2'd0);
    add(3'b000, ALL_RED, 2'd0);
    for (int i = 0; i < 4; i++) add(3'b000, 9'b100_001_100, 2'd1);
    for (int i = 0; i < 3; i++) add(3'b000, 9'b100_010_100, 2'd1);
    add(3'b000, ALL_RED, 2'd1);
    add(3'b000, 9'b100_100_001, 2'd0);
    add(3'b000, 9'b100_100_001, 2'd0);

    // Idle rest: phase 0 green indefinitely.
    do_reset();
    for (int i = 0; i < 50; i++) step('0, 1'b0, "idle");

    // Table-driven directed sequence.
    do_reset();
    foreach (tbl[i]) begin
      veh_sensor = tbl[i].sens;
      ped_button = 1'b0;
      @(posedge clk);
      model_step(tbl[i].sens, 1'b0);
      #1;
      check($sformatf("tbl[%0d] lights", i), 32'(lights), 32'(tbl[i].lights));
      check($sformatf("tbl[%0d] phase", i), 32'(active_phase), 32'(tbl[i].phase));
      check($sformatf("tbl[%0d] ped_walk", i), 32'(ped_walk), 32'd0);
    end

    // Max-out: phase 0 sensor held, phase 2 requested once.
    do_reset();
    green_cnt = 1;
    step(3'b101, 1'b0, "maxout");
    done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      if (lights[2:0] == 3'b001) begin
        green_cnt++;
        step(3'b001, 1'b0, "maxout");
      end else done = 1;
    end
    check("maxout green length", 32'(green_cnt), 32'(GMAX));
    saw_p1_green = 0;
    done = 0;
    for (int i = 0; i < 10 && !done; i++) begin
      step(3'b001, 1'b0, "maxout next");
      if (lights[5:3] == 3'b001) saw_p1_green = 1;
      if (lights[8:6] == 3'b001) done = 1;
    end
    check("maxout reached phase 2", 32'(done), 32'd1);
    check("maxout next phase", 32'(active_phase), 32'd2);
    check("maxout phase 1 skipped", 32'(saw_p1_green), 32'd0);

    // Pedestrian and vehicle in the same cycle.
    do_reset();
    step(3'b010, 1'b1, "ped");
    walk_cnt = 0; prev_walk = 0; first_green_after_walk = -1;
    for (int i = 0; i < 40; i++) begin
      step('0, 1'b0, "ped");
      if (ped_walk) begin
        walk_cnt++;
        check("walk all red", 32'(lights), 32'(ALL_RED));
      end
      if (prev_walk && !ped_walk && first_green_after_walk < 0) begin
        first_green_after_walk = active_phase;
        check("post-walk ped_pending", 32'(ped_pending), 32'd0);
        check("post-walk lights", 32'(lights), 32'(9'b100_001_100));
      end
      prev_walk = ped_walk;
    end
    check("walk length", 32'(walk_cnt), 32'(WT));
    check("post-walk phase", 32'(first_green_after_walk), 32'd1);

    // Asynchronous reset in the second yellow cycle.
    do_reset();
    step(3'b010, 1'b1, "rstmid");
    done = 0;
    for (int i = 0; i < 10 && !done; i++) begin
      step('0, 1'b0, "rstmid");
      if (lights[2:0] == 3'b010) done = 1;
    end
    check("rstmid reached yellow", 32'(done), 32'd1);
    step('0, 1'b0, "rstmid");
    #2;
    reset = 1'b1;
    #1;
    check("async reset lights", 32'(lights), 32'(RST_LIGHTS));
    check("async reset ped_walk", 32'(ped_walk), 32'd0);
    check("async reset phase", 32'(active_phase), 32'd0);
    check("async reset ped_pending", 32'(ped_pending), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 20; i++) step('0, 1'b0, "after rst");

`ifdef TLC_FLASH_MODE_EN
    do_reset();
    flash_mode = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("flash[%0d] lights", k), 32'(lights),
            32'((((k / 4) % 2) == 0) ? 9'b100_100_010 : 9'b000_000_000));
      check("flash ped_walk", 32'(ped_walk), 32'd0);
    end
    flash_mode = 1'b0;
    @(posedge clk);
    #1;
    check("flash release all red", 32'(lights), 32'(ALL_RED));
    @(posedge clk);
    #1;
    check("flash release green", 32'(lights), 32'(RST_LIGHTS));
`endif

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic [N-1:0] s;
      logic b;
      for (int j = 0; j < N; j++) s[j] = ($urandom_range(0, 9) < 2);
      b = ($urandom_range(0, 39) == 0);
      step(s, b, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
